// File: rtl/ling_pipe_adder_if.sv
// Valid/ready operand and result bundle for ling_pipe_adder.
// master drives operands and out_ready; slave is the adder.
interface ling_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ling_pipe_adder.sv
// Pipelined add/sub built from sparse-4 Ling segments,
// one segment per stage, global-stall valid/ready control.
module ling_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic              clk,
  input logic              rst,
  ling_pipe_adder_if.slave io
);
  localparam int NSEG = WIDTH / SEG;
  localparam int NBLK = SEG / 4;

  if ((WIDTH % SEG != 0) || (WIDTH < SEG) || (SEG % 4 != 0))
  begin : g_bad_param
    $error("ling_pipe_adder: WIDTH/SEG mismatch");
  end

  typedef logic [WIDTH-1:0] word_t;

  // h is the Ling pseudo-carry at 4-bit boundaries; c = t & h
  function automatic logic [SEG:0] ling_seg(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG-1:0] g, t, p, s;
    logic [SEG:0]   te;
    logic [NBLK:0]  h;
    logic           gs, ts, c;
    g  = x & y;
    t  = x | y;
    p  = x ^ y;
    te = {t, 1'b1};
    s  = '0;
    h  = '0;
    h[0] = ci;
    for (int j = 0; j < NBLK; j++) begin
      gs = g[4*j+3]
         | (t[4*j+2] & g[4*j+2])
         | (t[4*j+2] & t[4*j+1] & g[4*j+1])
         | (t[4*j+2] & t[4*j+1] & t[4*j] & g[4*j]);
      ts = t[4*j+2] & t[4*j+1] & t[4*j] & te[4*j];
      h[j+1] = gs | (ts & h[j]);
      c = te[4*j] & h[j];
      for (int i = 0; i < 4; i++) begin
        s[4*j+i] = p[4*j+i] ^ c;
        c = g[4*j+i] | (t[4*j+i] & c);
      end
    end
    return {t[SEG-1] & h[NBLK], s};
  endfunction

  word_t ra [NSEG];
  word_t rb [NSEG];
  word_t rs [NSEG];
  logic  rc [NSEG];
  logic  v  [NSEG];
  logic  rovf;

  word_t sa [NSEG];
  word_t sb [NSEG];
  word_t ss [NSEG];
  logic  sc [NSEG];
  logic  sv [NSEG];
  word_t ns [NSEG];
  logic  nc [NSEG];
  logic  nov;
  logic [SEG:0] seg;

  logic advance;
  logic accept;

  assign advance     = !v[NSEG-1] || io.out_ready;
  assign io.in_ready = advance && !rst;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    seg   = '0;
    sa[0] = io.a;
    sb[0] = io.sub ? ~io.b : io.b;
    ss[0] = '0;
    sc[0] = io.sub | io.cin;
    sv[0] = accept;
    for (int k = 1; k < NSEG; k++) begin
      sa[k] = ra[k-1];
      sb[k] = rb[k-1];
      ss[k] = rs[k-1];
      sc[k] = rc[k-1];
      sv[k] = v[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg = ling_seg(sa[k][k*SEG +: SEG],
                     sb[k][k*SEG +: SEG], sc[k]);
      ns[k] = ss[k];
      ns[k][k*SEG +: SEG] = seg[SEG-1:0];
      nc[k] = seg[SEG];
    end
    nov = (sa[NSEG-1][WIDTH-1] == sb[NSEG-1][WIDTH-1])
       && (ns[NSEG-1][WIDTH-1] != sa[NSEG-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        v[k]  <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
        rc[k] <= 1'b0;
      end
      rovf <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSEG; k++) begin
        v[k]  <= sv[k];
        ra[k] <= sa[k];
        rb[k] <= sb[k];
        rs[k] <= ns[k];
        rc[k] <= nc[k];
      end
      rovf <= nov;
    end
  end

  assign io.out_valid = v[NSEG-1];
  assign io.sum       = rs[NSEG-1];
  assign io.cout      = rc[NSEG-1];
  assign io.ovf       = rovf;
endmodule

// File: tb/tb_ling_pipe_adder.sv
// Bench for ling_pipe_adder: 32-bit/4-stage and 8-bit/1-stage
// instances checked against an arithmetic reference model.
module tb_ling_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ling_pipe_adder_if #(.WIDTH(32)) bus ();
  ling_pipe_adder_if #(.WIDTH(8))  bus8 ();

  ling_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .io(bus)
  );
  ling_pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .io(bus8)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {cout, ovf, result} from plain integer arithmetic at width w
  function automatic logic [33:0] model(input int w,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic ci,
                                       input logic s);
    longint m, half, ua, ub, sa, sb, r, sr;
    logic co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (s) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(ci);
      co = (r >= m);
      sr = sa + sb + longint'(ci);
    end
    ov = (sr >= half) || (sr < -half);
    r  = r & (m - 1);
    return {co, ov, r[31:0]};
  endfunction

  task automatic run_one(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic ci,
                         input logic s,
                         output logic [33:0] obs,
                         output int lat);
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.sub = s;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      step();
      lat++;
    end
    obs = {bus.cout, bus.ovf, bus.sum};
    step();
  endtask

  initial begin
    logic [33:0] obs;
    int lat;
    int accepted;
    int retired;
    logic [7:0] a8, b8;
    logic ci8, s8;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus8.sub = 1'b0;

    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outputs", 64'({bus.cout, bus.ovf, bus.sum}), 64'd0);
    chk("rst_out_valid8", 64'(bus8.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    step();

    run_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, obs, lat);
    chk("ripple_lat", 64'(lat), 64'd4);
    chk("ripple", 64'(obs), 64'({1'b1, 1'b0, 32'h0}));
    run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, obs, lat);
    chk("pos_ovf", 64'(obs), 64'({1'b0, 1'b1, 32'h8000_0000}));
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, obs, lat);
    chk("neg_ovf", 64'(obs), 64'({1'b1, 1'b1, 32'h0}));
    run_one(32'd5, 32'd7, 1'b1, 1'b1, obs, lat);
    chk("sub_borrow", 64'(obs), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
    run_one(32'd7, 32'd5, 1'b1, 1'b1, obs, lat);
    chk("sub_noborrow", 64'(obs), 64'({1'b1, 1'b0, 32'd2}));
    chk("sub_lat", 64'(lat), 64'd4);

    accepted = 0;
    retired = 0;
    for (int cyc = 0;
         cyc < 3000 && (accepted < 100 || q.size() > 0);
         cyc++) begin
      bus.in_valid = (accepted < 100);
      bus.a = $urandom;
      bus.b = $urandom;
      bus.cin = 1'($urandom_range(0, 1));
      bus.sub = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("in_ready_rule", 64'(bus.in_ready),
          64'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        chk("no_extra", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          chk("stream_data", 64'({bus.cout, bus.ovf, bus.sum}),
              64'(q[0]));
          if (bus.out_ready) begin
            void'(q.pop_front());
            retired++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(32, bus.a, bus.b, bus.cin, bus.sub));
        accepted++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_drain", 64'(q.size()), 64'd0);
    chk("stream_count", 64'(retired), 64'd100);

    for (int i = 0; i < 3; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      bus.in_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    #1;
    chk("in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", 64'(bus.out_valid), 64'd0);
      step();
    end
    run_one(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, obs, lat);
    chk("fresh_lat", 64'(lat), 64'd4);
    chk("fresh", 64'(obs),
        64'(model(32, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0)));

    bus8.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      a8 = 8'(i);
      b8 = 8'(i >> 8);
      ci8 = ((i % 3) == 1);
      s8 = ((i % 3) == 2);
      bus8.a = a8;
      bus8.b = b8;
      bus8.cin = ci8;
      bus8.sub = s8;
      bus8.in_valid = 1'b1;
      step();
      chk("w8", 64'({bus8.out_valid, bus8.cout, bus8.ovf,
                     24'h0, bus8.sum}),
          64'({1'b1, model(8, {24'h0, a8}, {24'h0, b8}, ci8, s8)}));
    end
    bus8.in_valid = 1'b0;
    step();
    chk("w8_idle", 64'(bus8.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
